// File: rtl/knn_vote_pkg.sv
// Shared definitions for the KNN majority-vote stage: widths, FSM states and
// the K clamp applied when a vote is started.
package knn_vote_pkg;

  localparam int unsigned W       = 32;
  localparam int unsigned HW_K    = 10;
  localparam int unsigned N_CLASS = 8;
  localparam int unsigned LABEL_W = 3;
  localparam int unsigned IDX_W   = W / 4;
  localparam int unsigned CNT_W   = $clog2(HW_K + 1);
  localparam int unsigned SEL_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_SEL  = 3'd2,
    S_ADDR = 3'd3,
    S_ACC  = 3'd4,
    S_SCAN = 3'd5,
    S_FIN  = 3'd6
  } state_e;

  // K=0 behaves as K=1; anything beyond the sorter depth uses the full depth.
  function automatic logic [CNT_W-1:0] clamp_k(input logic [SEL_W-1:0] k);
    if (k == '0) return CNT_W'(1);
    if (k > SEL_W'(HW_K)) return CNT_W'(HW_K);
    return CNT_W'(k);
  endfunction

endpackage

// File: rtl/knn_vote_argmax.sv
// Per-class vote counters with a one-class-per-cycle argmax scan.
// Ties keep the earlier (lower) class because only a strictly larger count wins.
module knn_vote_argmax
  import knn_vote_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_inc,
  input  logic [LABEL_W-1:0] i_label,
  input  logic               i_scan,
  output logic               o_scan_last_c,
  output logic [LABEL_W-1:0] o_best_nxt_c,
  output logic [CNT_W-1:0]   o_bestcnt_nxt_c
);

  logic [CNT_W-1:0]   r_count [N_CLASS];
  logic [LABEL_W-1:0] r_scan;
  logic [LABEL_W-1:0] r_best;
  logic [CNT_W-1:0]   r_bestcnt;
  logic               w_label_ok;
  logic               w_take;

  // Out-of-range labels only exist when the label space exceeds the class count.
  generate
    if (N_CLASS < (1 << LABEL_W)) begin : g_label_chk
      assign w_label_ok = (i_label < LABEL_W'(N_CLASS));
    end else begin : g_label_all
      assign w_label_ok = 1'b1;
    end
  endgenerate

  assign w_take          = (r_count[r_scan] > r_bestcnt);
  assign o_best_nxt_c    = w_take ? r_scan : r_best;
  assign o_bestcnt_nxt_c = w_take ? r_count[r_scan] : r_bestcnt;
  assign o_scan_last_c   = (r_scan == LABEL_W'(N_CLASS - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      for (int n = 0; n < int'(N_CLASS); n++) r_count[n] <= '0;
      r_scan    <= '0;
      r_best    <= '0;
      r_bestcnt <= '0;
    end else begin
      if (i_inc && w_label_ok && (r_count[i_label] != CNT_W'(HW_K)))
        r_count[i_label] <= r_count[i_label] + CNT_W'(1);
      if (i_scan) begin
        r_scan    <= r_scan + LABEL_W'(1);
        r_best    <= o_best_nxt_c;
        r_bestcnt <= o_bestcnt_nxt_c;
      end
    end
  end

endmodule

// File: rtl/knn_vote.sv
// KNN majority vote: walks the sorter's ranked list, fetches each neighbour's
// label, counts votes per class and reports the winner with a done pulse.
module knn_vote
  import knn_vote_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SEL_W-1:0]   K_IN,
  output logic [SEL_W-1:0]   SEL,
  input  logic [IDX_W-1:0]   NBR_IDX,
  output logic [IDX_W-1:0]   LABEL_ADDR,
  input  logic [LABEL_W-1:0] LABEL_IN,
  output logic               busy,
  output logic               done,
  output logic [LABEL_W-1:0] CLASS,
  output logic [CNT_W-1:0]   VOTES
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_k;
  logic [CNT_W-1:0]   r_i;
  logic [CNT_W-1:0]   w_i_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [IDX_W-1:0]   r_label_addr;
  logic               r_busy;
  logic               r_done;
  logic [LABEL_W-1:0] r_class;
  logic [CNT_W-1:0]   r_votes;

  logic               w_clr;
  logic               w_inc;
  logic               w_scan;
  logic               w_last_nbr;
  logic               w_scan_last;
  logic [LABEL_W-1:0] w_best_nxt;
  logic [CNT_W-1:0]   w_bestcnt_nxt;

  knn_vote_argmax u_argmax (
    .clk             (clk),
    .rst             (rst),
    .i_clr           (w_clr),
    .i_inc           (w_inc),
    .i_label         (LABEL_IN),
    .i_scan          (w_scan),
    .o_scan_last_c   (w_scan_last),
    .o_best_nxt_c    (w_best_nxt),
    .o_bestcnt_nxt_c (w_bestcnt_nxt)
  );

  assign w_last_nbr = (r_i == r_k - CNT_W'(1));

  // Next-state and counter strobes; each neighbour takes SEL -> ADDR -> ACC.
  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    w_scan      = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_CLR;
      S_CLR: begin
        w_clr       = 1'b1;
        w_i_nxt     = '0;
        w_state_nxt = S_SEL;
      end
      S_SEL:  w_state_nxt = S_ADDR;
      S_ADDR: w_state_nxt = S_ACC;
      S_ACC: begin
        w_inc = 1'b1;
        if (w_last_nbr) begin
          w_state_nxt = S_SCAN;
        end else begin
          w_i_nxt     = r_i + CNT_W'(1);
          w_state_nxt = S_SEL;
        end
      end
      S_SCAN: begin
        w_scan = 1'b1;
        if (w_scan_last) w_state_nxt = S_FIN;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered against the upcoming state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_i          <= '0;
      r_sel        <= '0;
      r_label_addr <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_class      <= '0;
      r_votes      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_busy  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_FIN);
      r_done  <= (w_state_nxt == S_FIN);
      if ((r_state == S_IDLE) && start) r_k <= clamp_k(K_IN);
      if (w_state_nxt == S_SEL) r_sel <= SEL_W'(w_i_nxt);
      if (r_state == S_ADDR) r_label_addr <= NBR_IDX;
      // The final scan step is folded in here so CLASS sees class N_CLASS-1.
      if ((r_state == S_SCAN) && w_scan_last) begin
        r_class <= w_best_nxt;
        r_votes <= w_bestcnt_nxt;
      end
    end
  end

  assign SEL        = r_sel;
  assign LABEL_ADDR = r_label_addr;
  assign busy       = r_busy;
  assign done       = r_done;
  assign CLASS      = r_class;
  assign VOTES      = r_votes;

endmodule

// File: tb/tb_knn_vote.sv
// Bench for knn_vote: sorter and label memory models, a scoreboard of expected
// votes computed from plain per-class counting, and a done-driven monitor.
module tb_knn_vote;
  import knn_vote_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [15:0]        K_IN;
  logic [15:0]        SEL;
  logic [IDX_W-1:0]   NBR_IDX;
  logic [IDX_W-1:0]   LABEL_ADDR;
  logic [LABEL_W-1:0] LABEL_IN;
  logic               busy;
  logic               done;
  logic [LABEL_W-1:0] CLASS;
  logic [CNT_W-1:0]   VOTES;

  knn_vote dut (
    .clk(clk), .rst(rst), .start(start), .K_IN(K_IN), .SEL(SEL),
    .NBR_IDX(NBR_IDX), .LABEL_ADDR(LABEL_ADDR), .LABEL_IN(LABEL_IN),
    .busy(busy), .done(done), .CLASS(CLASS), .VOTES(VOTES)
  );

  always #5 clk = ~clk;

  // Sorter: DATA_OUT follows SEL one cycle later. Label memory read data
  // follows the registered LABEL_ADDR.
  logic [IDX_W-1:0]   nbr_tbl [16];
  logic [LABEL_W-1:0] mem [1 << IDX_W];
  always @(posedge clk) NBR_IDX <= nbr_tbl[SEL[3:0]];
  assign LABEL_IN = mem[LABEL_ADDR];

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct { int cls; int votes; int edge_at; } exp_t;
  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic [15:0] sel_seen = '0;
  int sel_out_of_range = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      if (SEL < 16'd16) sel_seen[SEL[3:0]] = 1'b1;
      else sel_out_of_range++;
    end
    if (done) begin
      done_cnt++;
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check("class", int'(CLASS), e.cls);
        check("votes", int'(VOTES), e.votes);
        check("done_cycle", edges, e.edge_at);
      end
    end
  end

  // Reference: plain counting over the first K ranked neighbours.
  function automatic void model(input int k_in, output int cls, output int votes,
                                output int kk);
    int cnt [N_CLASS];
    int l;
    kk = (k_in == 0) ? 1 : ((k_in > int'(HW_K)) ? int'(HW_K) : k_in);
    for (int c = 0; c < int'(N_CLASS); c++) cnt[c] = 0;
    for (int j = 0; j < kk; j++) begin
      l = int'(mem[nbr_tbl[j]]);
      if (l < int'(N_CLASS)) cnt[l]++;
    end
    cls = 0;
    votes = 0;
    for (int c = 0; c < int'(N_CLASS); c++)
      if (cnt[c] > votes) begin
        cls = c;
        votes = cnt[c];
      end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Called one time-unit after an edge; leaves the bench in cycle 1 of the vote.
  task automatic issue(input int k_in);
    int c, v, kk;
    model(k_in, c, v, kk);
    K_IN  = 16'(k_in);
    start = 1'b1;
    step();
    start = 1'b0;
    // Done cycle 3K+N_CLASS+2 is seen at the negedge after edges has advanced.
    q.push_back('{c, v, edges + 3 * kk + int'(N_CLASS) + 1});
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int n = 0;
    while ((done_cnt == d0) && (n < 200)) begin
      step();
      n++;
    end
    if (done_cnt == d0) check("done_timeout", 0, 1);
  endtask

  task automatic randomize_tables();
    for (int j = 0; j < 16; j++) nbr_tbl[j] = IDX_W'($urandom_range(0, 255));
    for (int a = 0; a < (1 << IDX_W); a++) mem[a] = LABEL_W'($urandom);
  endtask

  task automatic set_labels(input int n, input int l0, input int l1, input int l2,
                            input int l3);
    int lab [4];
    lab = '{l0, l1, l2, l3};
    for (int j = 0; j < n; j++) begin
      nbr_tbl[j] = IDX_W'(10 + j);
      mem[10 + j] = LABEL_W'(lab[j]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    randomize_tables();
    rst = 1'b1;
    start = 1'b0;
    K_IN = '0;
    idle(3);
    rst = 1'b0;
    check("rst_sel", int'(SEL), 0);
    check("rst_label_addr", int'(LABEL_ADDR), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_class", int'(CLASS), 0);
    check("rst_votes", int'(VOTES), 0);
    idle(2);

    // Majority of three: labels {2,2,5}.
    set_labels(3, 2, 2, 5, 0);
    issue(3);
    check("busy_after_start", int'(busy), 1);
    wait_done();
    idle(2);

    // Tie between classes 1 and 6 resolves to 1.
    set_labels(4, 1, 6, 6, 1);
    issue(4);
    wait_done();
    idle(2);

    // K=0 acts as K=1.
    set_labels(1, 7, 0, 0, 0);
    issue(0);
    wait_done();
    check("busy_after_done", int'(busy), 0);
    idle(2);

    // Restart attempt mid-vote is ignored, then reset aborts the vote.
    set_labels(3, 3, 3, 1, 0);
    issue(3);
    idle(4);
    start = 1'b1;
    step();
    start = 1'b0;
    idle(2);
    check("sel_no_restart", int'(SEL), 2);
    check("busy_mid_vote", int'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    check("abort_busy", int'(busy), 0);
    check("abort_class", int'(CLASS), 0);
    check("abort_votes", int'(VOTES), 0);
    check("abort_sel", int'(SEL), 0);
    idle(40);
    check("abort_no_done", done_cnt, 3);

    // Fresh vote after the abort.
    randomize_tables();
    issue(5);
    wait_done();
    idle(2);

    // K_IN far above the sorter depth: exactly ranks 0..9 are visited.
    for (int j = 0; j < 16; j++) nbr_tbl[j] = IDX_W'(20 + j);
    for (int j = 0; j < 16; j++) mem[20 + j] = (j < int'(HW_K)) ? LABEL_W'(4) : LABEL_W'(1);
    sel_seen = '0;
    sel_out_of_range = 0;
    issue(50);
    wait_done();
    check("sel_ranks_seen", int'(sel_seen), 16'h03FF);
    check("sel_out_of_range", sel_out_of_range, 0);
    idle(2);

    // Back-to-back votes with different labels: no carry-over between runs.
    for (int j = 0; j < 10; j++) begin
      nbr_tbl[j] = IDX_W'(40 + j);
      mem[40 + j] = LABEL_W'(5);
    end
    issue(10);
    wait_done();
    for (int j = 0; j < 10; j++) mem[40 + j] = (j < 3) ? LABEL_W'(0) : LABEL_W'(6);
    issue(3);
    wait_done();

    // Randomised votes with random gaps, including zero-gap restarts.
    for (int t = 0; t < 25; t++) begin
      randomize_tables();
      k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(11, 65535))
                                      : int'($urandom_range(0, 12));
      issue(k);
      wait_done();
      idle(int'($urandom_range(0, 2)));
    end

    idle(5);
    check("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
